// File: rtl/calc_key_ctrl.sv
// Keypad cursor controller and left-to-right expression evaluator for the
// calculator LCD. Navigation/select pulses move a 4x4 cursor and edit a
// 16-character buffer; '=' scans the buffer one character per clock and
// publishes a 16-bit unsigned result.
module calc_key_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int GRID    = 4
) (
  input  logic         clk_in,
  input  logic         sys_rst_n,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_ok,
  output logic [3:0]   cursor_x,
  output logic [3:0]   cursor_y,
  output logic [127:0] disp_str_flat,
  output logic [15:0]  result,
  output logic         calc_done,
  output logic         busy
);

  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);
  localparam logic [3:0] EDGE    = 4'(GRID - 1);
  localparam logic [7:0] SPACE   = 8'h20;

  typedef enum logic [1:0] {IDLE, EVAL, FINISH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  chars [MAX_LEN];
  logic [4:0]  len, len_m1, idx;
  logic [15:0] acc, operand;
  logic [7:0]  pend_op, key, last_char, scan_char;
  logic        last_is_digit, eq_go;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == "+") || (c == "-") || (c == "*");
  endfunction

  function automatic logic [7:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] k;
    k = SPACE;
    case ({row, col})
      4'd0:  k = "1";
      4'd1:  k = "2";
      4'd2:  k = "3";
      4'd3:  k = "+";
      4'd4:  k = "4";
      4'd5:  k = "5";
      4'd6:  k = "6";
      4'd7:  k = "-";
      4'd8:  k = "7";
      4'd9:  k = "8";
      4'd10: k = "9";
      4'd11: k = "*";
      4'd12: k = "C";
      4'd13: k = "0";
      4'd14: k = "=";
      4'd15: k = "B";
    endcase
    return k;
  endfunction

  // All arithmetic is modulo 2^16; multiply keeps the low half.
  function automatic logic [15:0] apply_op(input logic [15:0] a, input logic [7:0] op,
                                           input logic [15:0] b);
    logic [15:0] r;
    case (op)
      "-":     r = a - b;
      "*":     r = a * b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] step_up(input logic [3:0] v);
    return (v == EDGE) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] step_dn(input logic [3:0] v);
    return (v == 4'd0) ? EDGE : v - 4'd1;
  endfunction

  // Key decode, buffer-tail inspection and next-state selection.
  always_comb begin
    state_nxt     = state;
    key           = key_at(cursor_y[1:0], cursor_x[1:0]);
    len_m1        = len - 5'd1;
    last_char     = (len == 5'd0) ? SPACE : chars[len_m1[3:0]];
    last_is_digit = is_digit(last_char);
    scan_char     = chars[idx[3:0]];
    eq_go         = (state == IDLE) && btn_ok && (key == "=") && last_is_digit;
    case (state)
      IDLE:    if (eq_go) state_nxt = EVAL;
      EVAL:    if (idx == len) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Cursor, buffer editing, and the sequential evaluator datapath.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cursor_x  <= 4'd0;
      cursor_y  <= 4'd0;
      for (int k = 0; k < MAX_LEN; k++) chars[k] <= SPACE;
      len       <= 5'd0;
      idx       <= 5'd0;
      acc       <= 16'd0;
      operand   <= 16'd0;
      pend_op   <= "+";
      result    <= 16'd0;
      calc_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_ok) begin
            if (is_digit(key) || is_op(key)) begin
              // An operator must follow a digit; digits only need room.
              if ((len < LEN_MAX) && (is_digit(key) || last_is_digit)) begin
                chars[len[3:0]] <= key;
                len             <= len + 5'd1;
                calc_done       <= 1'b0;
              end
            end else if (key == "B") begin
              if (len != 5'd0) begin
                chars[len_m1[3:0]] <= SPACE;
                len                <= len_m1;
                calc_done          <= 1'b0;
              end
            end else if (key == "C") begin
              for (int k = 0; k < MAX_LEN; k++) chars[k] <= SPACE;
              len       <= 5'd0;
              result    <= 16'd0;
              calc_done <= 1'b0;
            end else if (eq_go) begin
              busy      <= 1'b1;
              idx       <= 5'd0;
              acc       <= 16'd0;
              operand   <= 16'd0;
              pend_op   <= "+";
              calc_done <= 1'b0;
            end
          end else if (btn_up) begin
            cursor_y <= step_dn(cursor_y);
          end else if (btn_down) begin
            cursor_y <= step_up(cursor_y);
          end else if (btn_left) begin
            cursor_x <= step_dn(cursor_x);
          end else if (btn_right) begin
            cursor_x <= step_up(cursor_x);
          end
        end
        EVAL: begin
          // One extra pass with idx == len lets the last scan settle before FINISH.
          if (idx < len) begin
            if (is_digit(scan_char)) begin
              operand <= operand * 16'd10 + {12'd0, scan_char[3:0]};
            end else begin
              acc     <= apply_op(acc, pend_op, operand);
              pend_op <= scan_char;
              operand <= 16'd0;
            end
          end
          idx <= idx + 5'd1;
        end
        FINISH: begin
          result    <= apply_op(acc, pend_op, operand);
          calc_done <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Flatten the character buffer onto the display bus, char k at [k*8+:8].
  always_comb begin
    disp_str_flat = '0;
    for (int k = 0; k < MAX_LEN; k++) disp_str_flat[k*8 +: 8] = chars[k];
  end

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Scenario bench for calc_key_ctrl: drives keypad pulses, queues expected
// results as '=' is pressed, and pops them when calc_done appears.
module tb_calc_key_ctrl;

  logic         clk_in = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_ok = 1'b0;
  logic [3:0]   cursor_x, cursor_y;
  logic [127:0] disp_str_flat;
  logic [15:0]  result;
  logic         calc_done, busy;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [15:0]  sb[$];
  string        keys = "123+456-789*C0=B";
  int           cx = 0, cy = 0;

  localparam logic [127:0] ALL_SP = {16{8'h20}};

  calc_key_ctrl #(.MAX_LEN(16), .GRID(4)) dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_ok(btn_ok),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .disp_str_flat(disp_str_flat),
    .result(result), .calc_done(calc_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] flat_of(string s);
    logic [127:0] f = ALL_SP;
    for (int k = 0; k < s.len() && k < 16; k++) f[k*8 +: 8] = s[k];
    return f;
  endfunction

  // Reference evaluator: left to right, no precedence, 16-bit wrap.
  function automatic logic [15:0] model(string s);
    logic [15:0] a = 16'd0, num = 16'd0;
    byte op = "+";
    for (int i = 0; i <= s.len(); i++) begin
      byte c = (i < s.len()) ? s[i] : "=";
      if (c >= "0" && c <= "9") begin
        num = num * 16'd10 + 16'(c - "0");
      end else begin
        if (op == "+")      a = a + num;
        else if (op == "-") a = a - num;
        else                a = a * num;
        op  = c;
        num = 16'd0;
      end
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic pulse(input int b);
    case (b)
      0:       btn_up = 1'b1;
      1:       btn_down = 1'b1;
      2:       btn_left = 1'b1;
      3:       btn_right = 1'b1;
      default: btn_ok = 1'b1;
    endcase
    tick();
    {btn_up, btn_down, btn_left, btn_right, btn_ok} = 5'b0;
  endtask

  task automatic goto_key(input byte ch);
    int pos = 0;
    for (int i = 0; i < 16; i++) if (keys[i] == ch) pos = i;
    while (cx != pos % 4) begin pulse(3); cx = (cx + 1) % 4; end
    while (cy != pos / 4) begin pulse(1); cy = (cy + 1) % 4; end
  endtask

  task automatic press_key(input byte ch);
    goto_key(ch);
    pulse(4);
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) press_key(s[i]);
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (calc_done) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL reset_cursor_x: got %0d expected 0", cursor_x); end
    n_checks++; if (cursor_y !== 4'd0) begin n_fail++; $display("FAIL reset_cursor_y: got %0d expected 0", cursor_y); end
    n_checks++; if (disp_str_flat !== ALL_SP) begin n_fail++; $display("FAIL reset_disp: got %h expected %h", disp_str_flat, ALL_SP); end
    n_checks++; if (result !== 16'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
    n_checks++; if (calc_done !== 1'b0) begin n_fail++; $display("FAIL reset_calc_done: got %b expected 0", calc_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_nav();
    int ex[5] = '{3, 2, 1, 0, 3};
    for (int i = 0; i < 5; i++) begin
      pulse(2);
      n_checks++; if (cursor_x !== 4'(ex[i])) begin n_fail++; $display("FAIL nav_left_%0d: got %0d expected %0d", i, cursor_x, ex[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      pulse(0);
      n_checks++; if (cursor_y !== 4'(ex[i])) begin n_fail++; $display("FAIL nav_up_%0d: got %0d expected %0d", i, cursor_y, ex[i]); end
    end
    btn_up = 1'b1; btn_right = 1'b1;
    tick();
    btn_up = 1'b0; btn_right = 1'b0;
    n_checks++; if (cursor_y !== 4'd2) begin n_fail++; $display("FAIL nav_prio_y: got %0d expected 2", cursor_y); end
    n_checks++; if (cursor_x !== 4'd3) begin n_fail++; $display("FAIL nav_prio_x: got %0d expected 3", cursor_x); end
    cx = 3; cy = 2;
  endtask

  task automatic test_eval_basic();
    int  cyc = 0;
    bit  busy_ok = 1'b1;
    logic [15:0] exp_r;
    type_str("12+3*4");
    n_checks++; if (disp_str_flat !== flat_of("12+3*4")) begin n_fail++; $display("FAIL basic_disp: got %h expected %h", disp_str_flat, flat_of("12+3*4")); end
    n_checks++; if (disp_str_flat[7:0] !== 8'h31) begin n_fail++; $display("FAIL basic_char0: got %h expected 31", disp_str_flat[7:0]); end
    n_checks++; if (disp_str_flat[47:40] !== 8'h34) begin n_fail++; $display("FAIL basic_char5: got %h expected 34", disp_str_flat[47:40]); end
    goto_key("=");
    sb.push_back(16'd60);
    pulse(4);
    while (!calc_done && cyc < 30) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL basic_latency: got %0d edges expected 8", cyc); end
    n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL basic_busy_window: busy dropped early, expected 1 until done"); end
    exp_r = sb.pop_front();
    n_checks++; if (result !== exp_r) begin n_fail++; $display("FAIL basic_result: got %0d expected %0d", result, exp_r); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_arith();
    string tv[5] = '{"3-5", "999*999", "300*300", "70000", "65535+1"};
    bit got;
    logic [15:0] exp_r;
    for (int i = 0; i < 5; i++) begin
      press_key("C");
      type_str(tv[i]);
      goto_key("=");
      sb.push_back(model(tv[i]));
      pulse(4);
      wait_done(got);
      exp_r = sb.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL arith_%0d_timeout: calc_done=%b expected 1", i, calc_done); end
      else if (result !== exp_r) begin n_fail++; $display("FAIL arith_%0d_result: got %0d expected %0d", i, result, exp_r); end
    end
  endtask

  task automatic test_operator_rules();
    press_key("C");
    press_key("+");
    n_checks++; if (disp_str_flat !== ALL_SP) begin n_fail++; $display("FAIL op_empty: got %h expected %h", disp_str_flat, ALL_SP); end
    type_str("1++");
    n_checks++; if (disp_str_flat !== flat_of("1+")) begin n_fail++; $display("FAIL op_double: got %h expected %h", disp_str_flat, flat_of("1+")); end
    press_key("=");
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op_eq_busy: got %b expected 0", busy); end
    n_checks++; if (calc_done !== 1'b0) begin n_fail++; $display("FAIL op_eq_done: got %b expected 0", calc_done); end
    btn_ok = 1'b1; btn_up = 1'b1;
    tick();
    btn_ok = 1'b0; btn_up = 1'b0;
    n_checks++; if (cursor_y !== 4'd3) begin n_fail++; $display("FAIL op_ok_priority: got y=%0d expected 3", cursor_y); end
  endtask

  task automatic test_len_backspace();
    bit got;
    logic [15:0] exp_r;
    press_key("C");
    goto_key("1");
    repeat (17) pulse(4);
    n_checks++; if (disp_str_flat !== flat_of("1111111111111111")) begin n_fail++; $display("FAIL len_sat: got %h expected %h", disp_str_flat, flat_of("1111111111111111")); end
    press_key("B");
    pulse(4);
    n_checks++; if (disp_str_flat !== flat_of("11111111111111")) begin n_fail++; $display("FAIL backspace: got %h expected %h", disp_str_flat, flat_of("11111111111111")); end
    press_key("5");
    n_checks++; if (disp_str_flat !== flat_of("111111111111115")) begin n_fail++; $display("FAIL after_bs_append: got %h expected %h", disp_str_flat, flat_of("111111111111115")); end
    goto_key("=");
    sb.push_back(model("111111111111115"));
    pulse(4);
    wait_done(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL long_eval_timeout: calc_done=%b expected 1", calc_done); end
    else if (result !== exp_r) begin n_fail++; $display("FAIL long_eval_result: got %0d expected %0d", result, exp_r); end
    press_key("C");
    n_checks++; if (disp_str_flat !== ALL_SP) begin n_fail++; $display("FAIL clear_disp: got %h expected %h", disp_str_flat, ALL_SP); end
    n_checks++; if (result !== 16'd0) begin n_fail++; $display("FAIL clear_result: got %0d expected 0", result); end
    n_checks++; if (calc_done !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %b expected 0", calc_done); end
  endtask

  task automatic test_reset_mid_eval();
    press_key("C");
    type_str("12+3*4");
    goto_key("=");
    pulse(4);
    tick();
    tick();
    sys_rst_n = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (calc_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", calc_done); end
    n_checks++; if (result !== 16'd0) begin n_fail++; $display("FAIL midrst_result: got %0d expected 0", result); end
    n_checks++; if ({cursor_x, cursor_y} !== 8'd0) begin n_fail++; $display("FAIL midrst_cursor: got %0d,%0d expected 0,0", cursor_x, cursor_y); end
    n_checks++; if (disp_str_flat !== ALL_SP) begin n_fail++; $display("FAIL midrst_disp: got %h expected %h", disp_str_flat, ALL_SP); end
    cx = 0; cy = 0;
    tick();
    sys_rst_n = 1'b1;
    repeat (10) tick();
    n_checks++; if (calc_done !== 1'b0 || result !== 16'd0) begin n_fail++; $display("FAIL midrst_after: got done=%b result=%0d expected 0,0", calc_done, result); end
  endtask

  task automatic test_busy_drop();
    bit got;
    logic [15:0] exp_r;
    type_str("9*9");
    goto_key("=");
    sb.push_back(model("9*9"));
    pulse(4);
    pulse(2);
    pulse(0);
    pulse(4);
    n_checks++; if (cursor_x !== 4'd2 || cursor_y !== 4'd3) begin n_fail++; $display("FAIL busy_cursor: got %0d,%0d expected 2,3", cursor_x, cursor_y); end
    n_checks++; if (disp_str_flat !== flat_of("9*9")) begin n_fail++; $display("FAIL busy_disp: got %h expected %h", disp_str_flat, flat_of("9*9")); end
    wait_done(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL busy_eval_timeout: calc_done=%b expected 1", calc_done); end
    else if (result !== exp_r) begin n_fail++; $display("FAIL busy_eval_result: got %0d expected %0d", result, exp_r); end
  endtask

  task automatic test_reeval();
    bit got;
    logic [15:0] exp_r;
    sb.push_back(model("9*9"));
    pulse(4);
    wait_done(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL reeval_timeout: calc_done=%b expected 1", calc_done); end
    else if (result !== exp_r) begin n_fail++; $display("FAIL reeval_result: got %0d expected %0d", result, exp_r); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reeval_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_nav();
    test_eval_basic();
    test_arith();
    test_operator_rules();
    test_len_backspace();
    test_reset_mid_eval();
    test_busy_drop();
    test_reeval();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
